// File: rtl/cache_pkg.sv
// Shared widths, address field helpers and fill-FSM state type for the direct-mapped cache.
// Optional feature macro used by cache_top: CACHE_STATS_EN.
package cache_pkg;

   localparam int ADDR_BW    = 10;
   localparam int DATA_BW    = 32;
   localparam int LINE_WORDS = 4;
   localparam int LINES      = 16;
   localparam int OFFSET_BW  = $clog2(LINE_WORDS);
   localparam int INDEX_BW   = $clog2(LINES);
   localparam int TAG_BW     = ADDR_BW - INDEX_BW - OFFSET_BW;

   typedef logic [ADDR_BW-1:0]   addr_t;
   typedef logic [DATA_BW-1:0]   data_t;
   typedef logic [OFFSET_BW-1:0] offset_t;
   typedef logic [INDEX_BW-1:0]  index_t;
   typedef logic [TAG_BW-1:0]    tag_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_RESPOND
   } state_e;

   typedef struct packed {
      logic  wren;
      addr_t addr;
      data_t data;
   } req_t;

   function automatic offset_t addr_offset(input addr_t addr);
      return addr[OFFSET_BW-1:0];
   endfunction

   function automatic index_t addr_index(input addr_t addr);
      return addr[OFFSET_BW +: INDEX_BW];
   endfunction

   function automatic tag_t addr_tag(input addr_t addr);
      return addr[ADDR_BW-1 -: TAG_BW];
   endfunction

endpackage

// File: rtl/cache_backing_mem.sv
// Word-addressed synchronous RAM behind the cache: one write port, one read port, 1-cycle read latency.
// Words are stored XOR-ed with their address so a zero-initialised array reads back mem[i] = i.
module cache_backing_mem #(
   parameter int AW = cache_pkg::ADDR_BW,
   parameter int DW = cache_pkg::DATA_BW
) (
   input  logic          clock_i,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [2**AW];
   logic [DW-1:0] rd_word_q;
   logic [AW-1:0] rd_addr_q;

   // NOTE: RAM contents carry no reset; only control state is reset, so this maps onto block RAM.
   always_ff @(posedge clock_i) begin
      if (wr_en) mem[wr_addr] <= wr_data ^ DW'(wr_addr);
      rd_word_q <= mem[rd_addr];
      rd_addr_q <= rd_addr;
   end

   assign rd_data = rd_word_q ^ DW'(rd_addr_q);

endmodule

// File: rtl/cache_top.sv
// Direct-mapped, write-through, no-write-allocate cache with in-order read return and miss stall.
// Define CACHE_STATS_EN to add saturating read hit/miss counters on hit_count_o / miss_count_o.
module cache_top
   import cache_pkg::*;
(
   input  logic               clock_i,
   input  logic               reset_i,
   output logic               stall_o,
   input  logic               core_request_i,
   input  logic               core_wren_i,
   input  logic [ADDR_BW-1:0] core_addr_i,
   input  logic [DATA_BW-1:0] core_data_i,
   output logic               core_valid_o,
   output logic [DATA_BW-1:0] core_data_o
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0]        hit_count_o,
   output logic [31:0]        miss_count_o
`endif
);

   typedef logic [OFFSET_BW:0] cnt_t;

   state_e state_q, state_d;

   // The stage-1 register doubles as the skid buffer: it is frozen outside IDLE.
   logic    req_vld_q;
   req_t    req_q;
   addr_t   miss_addr_q;
   cnt_t    issue_cnt_q;
   logic    pend_vld_q;
   offset_t pend_off_q;

   logic [LINES-1:0] valid_q;
   tag_t             tag_arr  [LINES];
   data_t            data_arr [LINES][LINE_WORDS];

   index_t  req_idx, miss_idx;
   offset_t req_off, miss_off;
   logic    req_hit, accept;
   logic    rd_hit, rd_miss, wr_op, fill_done;
   addr_t   mem_raddr;
   data_t   mem_rdata;

   assign req_idx  = addr_index(req_q.addr);
   assign req_off  = addr_offset(req_q.addr);
   assign miss_idx = addr_index(miss_addr_q);
   assign miss_off = addr_offset(miss_addr_q);
   assign req_hit  = valid_q[req_idx] && (tag_arr[req_idx] == addr_tag(req_q.addr));
   assign accept   = core_request_i && !stall_o;

   // NOTE: every comb output gets a default first, so no path through the case infers a latch.
   always_comb begin
      state_d   = state_q;
      rd_hit    = 1'b0;
      rd_miss   = 1'b0;
      wr_op     = 1'b0;
      fill_done = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (req_vld_q) begin
               if (req_q.wren) begin
                  wr_op = 1'b1;
               end else if (req_hit) begin
                  rd_hit = 1'b1;
               end else begin
                  rd_miss = 1'b1;
                  state_d = ST_FILL;
               end
            end
         end
         ST_FILL: begin
            if (pend_vld_q && (pend_off_q == offset_t'(LINE_WORDS-1))) begin
               fill_done = 1'b1;
               state_d   = ST_RESPOND;
            end
         end
         ST_RESPOND: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // NOTE: all sequential state uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         stall_o      <= 1'b0;
         core_valid_o <= 1'b0;
         core_data_o  <= '0;
         req_vld_q    <= 1'b0;
         req_q        <= '0;
         miss_addr_q  <= '0;
         issue_cnt_q  <= '0;
         pend_vld_q   <= 1'b0;
         pend_off_q   <= '0;
         valid_q      <= '0;
      end else begin
         stall_o      <= (state_d != ST_IDLE);
         core_valid_o <= rd_hit || (state_q == ST_RESPOND);
         if (rd_hit)                      core_data_o <= data_arr[req_idx][req_off];
         else if (state_q == ST_RESPOND)  core_data_o <= data_arr[miss_idx][miss_off];

         if (state_q == ST_IDLE) begin
            req_vld_q <= accept;
            if (accept) req_q <= '{wren: core_wren_i, addr: core_addr_i, data: core_data_i};
         end

         if (rd_miss) miss_addr_q <= req_q.addr;

         // Fill issues one RAM read per cycle; pend_* tracks the word arriving next cycle.
         if (rd_miss)
            issue_cnt_q <= '0;
         else if ((state_q == ST_FILL) && !issue_cnt_q[OFFSET_BW])
            issue_cnt_q <= issue_cnt_q + cnt_t'(1);
         pend_vld_q <= (state_q == ST_FILL) && !issue_cnt_q[OFFSET_BW];
         pend_off_q <= issue_cnt_q[OFFSET_BW-1:0];

         if (fill_done) valid_q[miss_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clock_i) begin
      if (wr_op && req_hit)                     data_arr[req_idx][req_off] <= req_q.data;
      if ((state_q == ST_FILL) && pend_vld_q)   data_arr[miss_idx][pend_off_q] <= mem_rdata;
      if (fill_done)                            tag_arr[miss_idx] <= addr_tag(miss_addr_q);
   end

   assign mem_raddr = {miss_addr_q[ADDR_BW-1:OFFSET_BW], issue_cnt_q[OFFSET_BW-1:0]};

   cache_backing_mem #(
      .AW (ADDR_BW),
      .DW (DATA_BW)
   ) u_mem (
      .clock_i (clock_i),
      .wr_en   (wr_op),
      .wr_addr (req_q.addr),
      .wr_data (req_q.data),
      .rd_addr (mem_raddr),
      .rd_data (mem_rdata)
   );

`ifdef CACHE_STATS_EN
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         hit_count_o  <= '0;
         miss_count_o <= '0;
      end else begin
         if (rd_hit && (hit_count_o != '1))   hit_count_o  <= hit_count_o + 32'd1;
         if (rd_miss && (miss_count_o != '1)) miss_count_o <= miss_count_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cache_top.sv
// Scoreboard bench for cache_top: reads push shadow-memory values at acceptance, a monitor pops them on core_valid_o.
// Builds with or without CACHE_STATS_EN.
module tb_cache_top;
   import cache_pkg::*;

   logic  clock_i = 1'b0;
   logic  reset_i;
   logic  stall_o;
   logic  core_request_i;
   logic  core_wren_i;
   addr_t core_addr_i;
   data_t core_data_i;
   logic  core_valid_o;
   data_t core_data_o;
`ifdef CACHE_STATS_EN
   logic [31:0] hit_count_o;
   logic [31:0] miss_count_o;
`endif

   int    checks = 0;
   int    errors = 0;
   data_t shadow [2**ADDR_BW];
   data_t exp_q [$];

   cache_top dut (
      .clock_i        (clock_i),
      .reset_i        (reset_i),
      .stall_o        (stall_o),
      .core_request_i (core_request_i),
      .core_wren_i    (core_wren_i),
      .core_addr_i    (core_addr_i),
      .core_data_i    (core_data_i),
      .core_valid_o   (core_valid_o),
      .core_data_o    (core_data_o)
`ifdef CACHE_STATS_EN
      ,
      .hit_count_o    (hit_count_o),
      .miss_count_o   (miss_count_o)
`endif
   );

   always #5 clock_i = ~clock_i;

   // Read-return monitor, sampled on the falling edge.
   always @(negedge clock_i) begin
      data_t e;
      if (reset_i === 1'b0 && core_valid_o === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid got=%h expected no response", core_data_o);
         end else begin
            e = exp_q.pop_front();
            if (core_data_o !== e) begin
               errors++;
               $display("FAIL read_data got=%h expected=%h", core_data_o, e);
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "simulation did not finish");
   end

   // Drives one request from posedge+1, holds it until accepted, returns at posedge+1 after acceptance.
   task automatic issue(input logic wr, input addr_t a, input data_t d);
      int guard;
      guard = 0;
      core_request_i = 1'b1;
      core_wren_i    = wr;
      core_addr_i    = a;
      core_data_i    = d;
      while (stall_o !== 1'b0 && guard < 50) begin
         @(posedge clock_i); #1;
         guard++;
      end
      if (guard >= 50) begin
         checks++;
         errors++;
         $display("FAIL issue_stall_timeout addr=%0d stall=%b", a, stall_o);
      end
      if (wr) shadow[a] = d;
      else    exp_q.push_back(shadow[a]);
      @(posedge clock_i); #1;
   endtask

   task automatic idle(input int n);
      core_request_i = 1'b0;
      repeat (n) begin
         @(posedge clock_i); #1;
      end
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      core_request_i = 1'b0;
      while (exp_q.size() != 0 && guard < 200) begin
         @(negedge clock_i);
         guard++;
      end
      @(posedge clock_i); #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_outstanding got=%0d reads pending expected=0", exp_q.size());
      end
   endtask

   task automatic check_bit(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%b expected=%b", name, got, exp);
      end
   endtask

   task automatic test_reset();
      reset_i        = 1'b1;
      core_request_i = 1'b0;
      core_wren_i    = 1'b0;
      core_addr_i    = '0;
      core_data_i    = '0;
      repeat (2) @(posedge clock_i);
      #1;
      check_bit("reset_stall", stall_o, 1'b0);
      check_bit("reset_valid", core_valid_o, 1'b0);
      checks++;
      if (core_data_o !== '0) begin
         errors++;
         $display("FAIL reset_data got=%h expected=0", core_data_o);
      end
      reset_i = 1'b0;
      @(posedge clock_i); #1;
   endtask

   task automatic test_cold_read();
      int cyc;
      issue(1'b0, addr_t'(5), '0);
      core_request_i = 1'b0;
      @(posedge clock_i); #1;
      check_bit("cold_stall_rise", stall_o, 1'b1);
      cyc = 0;
      while (stall_o === 1'b1 && cyc < 30) begin
         @(posedge clock_i); #1;
         cyc++;
      end
      checks++;
      if (cyc > LINE_WORDS + 3) begin
         errors++;
         $display("FAIL cold_miss_penalty got=%0d cycles expected<=%0d", cyc, LINE_WORDS + 3);
      end
      check_bit("cold_valid_at_stall_drop", core_valid_o, 1'b1);
      @(posedge clock_i); #1;
      check_bit("cold_valid_one_cycle", core_valid_o, 1'b0);
      check_bit("cold_stall_low_after", stall_o, 1'b0);
      drain();
   endtask

   task automatic test_line_hits();
      issue(1'b0, addr_t'(4), '0);
      for (int i = 5; i <= 7; i++) begin
         issue(1'b0, addr_t'(i), '0);
         check_bit("b2b_hit_valid", core_valid_o, 1'b1);
         check_bit("b2b_hit_no_stall", stall_o, 1'b0);
      end
      core_request_i = 1'b0;
      @(posedge clock_i); #1;
      check_bit("b2b_last_valid", core_valid_o, 1'b1);
      @(posedge clock_i); #1;
      check_bit("b2b_done_valid", core_valid_o, 1'b0);
      drain();
   endtask

   task automatic test_write_read();
      // Miss case: line of address 9 not cached yet.
      issue(1'b1, addr_t'(9), 32'hDEADBEEF);
      issue(1'b0, addr_t'(9), '0);
      drain();
      // Hit case: the line is now resident.
      issue(1'b1, addr_t'(10), 32'hDEADBEEF);
      issue(1'b0, addr_t'(10), '0);
      core_request_i = 1'b0;
      @(posedge clock_i); #1;
      check_bit("wr_rd_hit_valid", core_valid_o, 1'b1);
      check_bit("wr_rd_hit_no_stall", stall_o, 1'b0);
      issue(1'b1, addr_t'(9), 32'h0BADF00D);
      issue(1'b0, addr_t'(9), '0);
      drain();
   endtask

   task automatic test_write_uncached();
      issue(1'b1, addr_t'(100), 32'h12345678);
      idle(2);
      issue(1'b0, addr_t'(100), '0);
      core_request_i = 1'b0;
      @(posedge clock_i); #1;
      check_bit("no_alloc_read_misses", stall_o, 1'b1);
      drain();
   endtask

   task automatic test_skid();
      issue(1'b0, addr_t'(300), '0);
      issue(1'b1, addr_t'(301), 32'hA5A50001);
      check_bit("skid_stall_high", stall_o, 1'b1);
      issue(1'b0, addr_t'(301), '0);
      issue(1'b0, addr_t'(300), '0);
      drain();
   endtask

   task automatic test_reset_mid_fill();
      issue(1'b0, addr_t'(200), '0);
      core_request_i = 1'b0;
      @(posedge clock_i); #1;
      @(posedge clock_i); #3;
      reset_i = 1'b1;
      #1;
      check_bit("midfill_reset_stall", stall_o, 1'b0);
      check_bit("midfill_reset_valid", core_valid_o, 1'b0);
      checks++;
      if (core_data_o !== '0) begin
         errors++;
         $display("FAIL midfill_reset_data got=%h expected=0", core_data_o);
      end
      exp_q.delete();
      @(posedge clock_i); #1;
      reset_i = 1'b0;
      @(posedge clock_i); #1;
      issue(1'b0, addr_t'(200), '0);
      core_request_i = 1'b0;
      @(posedge clock_i); #1;
      check_bit("post_reset_read_misses", stall_o, 1'b1);
      drain();
      issue(1'b0, addr_t'(5), '0);
      core_request_i = 1'b0;
      @(posedge clock_i); #1;
      check_bit("post_reset_old_line_invalid", stall_o, 1'b1);
      drain();
   endtask

   task automatic test_random();
      logic  wr;
      addr_t a;
      for (int n = 0; n < 10000; n++) begin
         wr = ($urandom_range(0, 99) < 30);
         if ($urandom_range(0, 4) != 0) a = addr_t'($urandom_range(0, 63));
         else                           a = addr_t'($urandom_range(0, 2**ADDR_BW - 1));
         issue(wr, a, data_t'($urandom()));
         if ($urandom_range(0, 7) == 0) idle(1);
      end
      drain();
   endtask

   initial begin
      for (int i = 0; i < 2**ADDR_BW; i++) shadow[i] = data_t'(i);
      test_reset();
      test_cold_read();
      test_line_hits();
      test_write_read();
      test_write_uncached();
      test_skid();
      test_reset_mid_fill();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
